// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the write-back, direct-mapped data cache controller.
// Holds the controller state encoding, the default address field widths, the position
// of the valid/dirty flags in the SRAM tag word, and the performance counter width.
// The optional hit/miss counters are enabled with the DCACHE_PERF_CNT_EN macro.
package dcache_pkg;

    localparam int DC_ADDR_W    = 32;
    localparam int DC_INDEX_W   = 4;
    localparam int DC_OFFSET_W  = 5;
    localparam int DC_TAG_W     = DC_ADDR_W - DC_INDEX_W - DC_OFFSET_W;  // 23
    localparam int DC_LINE_W    = 256;
    localparam int DC_WORD_W    = 32;
    localparam int DC_WSEL_W    = 3;
    localparam int DC_VALID_BIT = 24;
    localparam int DC_DIRTY_BIT = 23;
    localparam int DC_CNT_W     = 32;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MISS       = 3'd1,
        WRITEBACK  = 3'd2,
        READMISS   = 3'd3,
        READMISSOK = 3'd4
    } dc_state_t;

endpackage

// File: rtl/dcache_perf_cnt.sv
// dcache_perf_cnt: saturating hit and miss event counters for dcache_ctrl.
// Only instantiated when DCACHE_PERF_CNT_EN is defined.
// Ports:
//   clk_i, rst_n_i       clock, async active-low reset (counters clear to 0)
//   hit_i, miss_i        one-cycle event strobes
//   hit_cnt_o, miss_cnt_o  event counts, stick at all-ones
module dcache_perf_cnt
    import dcache_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                hit_i,
    input  logic                miss_i,
    output logic [DC_CNT_W-1:0] hit_cnt_o,
    output logic [DC_CNT_W-1:0] miss_cnt_o
);

    logic [DC_CNT_W-1:0] r_hit_cnt;
    logic [DC_CNT_W-1:0] r_miss_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (hit_i && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
            if (miss_i && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: write-back, write-allocate, direct-mapped data cache controller.
// CPU side: cpu_req_i/cpu_we_i/cpu_addr_i/cpu_data_i in, cpu_data_o/cpu_stall_o out.
// SRAM side: sram_addr_o/sram_tag_o/sram_data_o/sram_enable_o/sram_write_o out,
//            sram_tag_i/sram_data_i/sram_hit_i in (tag word = {valid, dirty, tag}).
// Memory side: mem_enable_o/mem_write_o/mem_addr_o/mem_data_o out (held until ack),
//              mem_data_i/mem_ack_i in.
// Optional: DCACHE_PERF_CNT_EN adds hit_cnt_o/miss_cnt_o.
//
// state      | meaning
// IDLE       | look up the addressed set; hits complete in the same cycle
// MISS       | read victim tag/data of the set, decide whether it is dirty
// WRITEBACK  | write dirty victim line to memory, wait for ack
// READMISS   | fetch the requested line from memory, wait for ack
// READMISSOK | install fetched line as valid/clean, then retry in IDLE
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_W = DC_INDEX_W
) (
    input  logic                                    clk_i,
    input  logic                                    rst_n_i,
    input  logic                                    cpu_req_i,
    input  logic                                    cpu_we_i,
    input  logic [DC_ADDR_W-1:0]                    cpu_addr_i,
    input  logic [DC_WORD_W-1:0]                    cpu_data_i,
    output logic [DC_WORD_W-1:0]                    cpu_data_o,
    output logic                                    cpu_stall_o,
    output logic [INDEX_W-1:0]                      sram_addr_o,
    output logic [DC_ADDR_W-INDEX_W-DC_OFFSET_W+1:0] sram_tag_o,
    output logic [DC_LINE_W-1:0]                    sram_data_o,
    output logic                                    sram_enable_o,
    output logic                                    sram_write_o,
    input  logic [DC_ADDR_W-INDEX_W-DC_OFFSET_W+1:0] sram_tag_i,
    input  logic [DC_LINE_W-1:0]                    sram_data_i,
    input  logic                                    sram_hit_i,
    output logic                                    mem_enable_o,
    output logic                                    mem_write_o,
    output logic [DC_ADDR_W-1:0]                    mem_addr_o,
    output logic [DC_LINE_W-1:0]                    mem_data_o,
    input  logic [DC_LINE_W-1:0]                    mem_data_i,
    input  logic                                    mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
   ,output logic [DC_CNT_W-1:0]                     hit_cnt_o,
    output logic [DC_CNT_W-1:0]                     miss_cnt_o
`endif
);

    localparam int TAG_W = DC_ADDR_W - INDEX_W - DC_OFFSET_W;
    // flag positions sit directly above the tag field
    localparam int V_BIT = TAG_W + (DC_VALID_BIT - DC_TAG_W);
    localparam int D_BIT = TAG_W + (DC_DIRTY_BIT - DC_TAG_W);

    dc_state_t              r_state;
    dc_state_t              w_next;
    logic [TAG_W-1:0]       r_tag;
    logic [INDEX_W-1:0]     r_index;
    logic [TAG_W-1:0]       r_vtag;
    logic [DC_LINE_W-1:0]   r_vdata;
    logic [DC_LINE_W-1:0]   r_fill;

    logic [TAG_W-1:0]       w_tag;
    logic [INDEX_W-1:0]     w_index;
    logic [DC_WSEL_W-1:0]   w_wsel;
    logic [DC_LINE_W-1:0]   w_merged;
    logic                   w_lookup;
    logic                   w_unused_byte;

    assign w_tag         = cpu_addr_i[DC_ADDR_W-1 -: TAG_W];
    assign w_index       = cpu_addr_i[DC_OFFSET_W +: INDEX_W];
    assign w_wsel        = cpu_addr_i[DC_OFFSET_W-1 -: DC_WSEL_W];
    assign w_unused_byte = ^cpu_addr_i[1:0];
    assign w_lookup      = (r_state == IDLE) && cpu_req_i;

    always_comb begin
        w_merged = sram_data_i;
        w_merged[DC_WORD_W*w_wsel +: DC_WORD_W] = cpu_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_tag   <= '0;
            r_index <= '0;
            r_vtag  <= '0;
            r_vdata <= '0;
            r_fill  <= '0;
        end else begin
            r_state <= w_next;
            // address is captured only when leaving IDLE on a miss
            if (w_lookup && !sram_hit_i) begin
                r_tag   <= w_tag;
                r_index <= w_index;
            end
            if (r_state == MISS) begin
                r_vtag  <= sram_tag_i[TAG_W-1:0];
                r_vdata <= sram_data_i;
            end
            if ((r_state == READMISS) && mem_ack_i) begin
                r_fill <= mem_data_i;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        cpu_stall_o   = 1'b0;
        cpu_data_o    = '0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        sram_addr_o   = '0;
        sram_tag_o    = '0;
        sram_data_o   = '0;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        // outputs are gated by reset so they drop without waiting for a clock edge
        if (rst_n_i) begin
            case (r_state)
                IDLE: begin
                    if (cpu_req_i) begin
                        sram_enable_o = 1'b1;
                        sram_addr_o   = w_index;
                        sram_tag_o    = {1'b1, 1'b0, w_tag};
                        if (sram_hit_i) begin
                            cpu_data_o = sram_data_i[DC_WORD_W*w_wsel +: DC_WORD_W];
                            if (cpu_we_i) begin
                                sram_write_o      = 1'b1;
                                sram_data_o       = w_merged;
                                sram_tag_o[D_BIT] = 1'b1;
                            end
                        end else begin
                            cpu_stall_o = 1'b1;
                            w_next      = MISS;
                        end
                    end
                end
                MISS: begin
                    cpu_stall_o   = 1'b1;
                    sram_enable_o = 1'b1;
                    sram_addr_o   = r_index;
                    sram_tag_o    = {1'b1, 1'b0, r_tag};
                    w_next = (sram_tag_i[V_BIT] && sram_tag_i[D_BIT]) ? WRITEBACK : READMISS;
                end
                WRITEBACK: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_write_o  = 1'b1;
                    mem_addr_o   = {r_vtag, r_index, {DC_OFFSET_W{1'b0}}};
                    mem_data_o   = r_vdata;
                    if (mem_ack_i) begin
                        w_next = READMISS;
                    end
                end
                READMISS: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_addr_o   = {r_tag, r_index, {DC_OFFSET_W{1'b0}}};
                    if (mem_ack_i) begin
                        w_next = READMISSOK;
                    end
                end
                READMISSOK: begin
                    cpu_stall_o   = 1'b1;
                    sram_enable_o = 1'b1;
                    sram_write_o  = 1'b1;
                    sram_addr_o   = r_index;
                    sram_tag_o    = {1'b1, 1'b0, r_tag};
                    sram_data_o   = r_fill;
                    w_next        = IDLE;
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic w_hit_evt;
    logic w_miss_evt;

    assign w_hit_evt  = w_lookup && sram_hit_i;
    assign w_miss_evt = w_lookup && !sram_hit_i;

    dcache_perf_cnt u_perf_cnt (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .hit_i      (w_hit_evt),
        .miss_i     (w_miss_evt),
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
    );
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed and randomized checks of dcache_ctrl against a
// flat-memory / direct-mapped-tag reference model kept in the bench.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    localparam int LAT         = 10;             // memory ack latency in enabled cycles
    localparam int CLEAN_STALL = 3 + (LAT + 1);  // lookup, MISS, READMISS, READMISSOK
    localparam int DIRTY_STALL = CLEAN_STALL + (LAT + 1);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req_i, cpu_we_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o, sram_tag_i;
    logic [255:0] sram_data_o, sram_data_i;
    logic         sram_enable_o, sram_write_o, sram_hit_i;
    logic         mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_PERF_CNT_EN
       ,.hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
`endif
    );

    // ---------------- external SRAM (tag + line store, 16 sets) ----------------
    logic [24:0]  s_tag  [16];
    logic [255:0] s_data [16];
    assign sram_tag_i  = s_tag[sram_addr_o];
    assign sram_data_i = s_data[sram_addr_o];
    assign sram_hit_i  = s_tag[sram_addr_o][DC_VALID_BIT] &&
                         (s_tag[sram_addr_o][22:0] == sram_tag_o[22:0]);
    always @(posedge clk) begin
        if (sram_enable_o && sram_write_o) begin
            s_tag[sram_addr_o]  <= sram_tag_o;
            s_data[sram_addr_o] <= sram_data_o;
        end
    end

    // ---------------- main memory responder ----------------
    function automatic logic [31:0] word_default(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    bit [255:0]   mem_store [bit [31:0]];
    logic [31:0]  wb_addr_q [$];
    logic [255:0] wb_data_q [$];
    int           fill_cnt = 0;
    logic [31:0]  last_fill_addr = '0;
    int           rcnt;

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        if (mem_store.exists(la)) return mem_store[la];
        for (int i = 0; i < 8; i++) l[32*i +: 32] = word_default(la + 32'(4*i));
        return l;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ack_i <= 1'b0;
            rcnt      <= 0;
        end else if (mem_ack_i) begin
            mem_ack_i <= 1'b0;
            rcnt      <= 0;
        end else if (mem_enable_o) begin
            if (rcnt == LAT - 1) begin
                mem_ack_i <= 1'b1;
                rcnt      <= 0;
                if (mem_write_o) begin
                    mem_store[mem_addr_o] = mem_data_o;
                    wb_addr_q.push_back(mem_addr_o);
                    wb_data_q.push_back(mem_data_o);
                end else begin
                    mem_data_i <= mem_line(mem_addr_o);
                    fill_cnt++;
                    last_fill_addr = mem_addr_o;
                end
            end else begin
                rcnt <= rcnt + 1;
            end
        end
    end

    // ---------------- reference model ----------------
    bit [31:0] ref_mem [bit [31:0]];
    bit        ref_v [16];
    bit        ref_d [16];
    bit [22:0] ref_t [16];
    int        exp_hits = 0, exp_misses = 0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        return ref_mem.exists(wa) ? ref_mem[wa] : word_default(wa);
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = ref_rd(la + 32'(4*i));
        return l;
    endfunction

    task automatic ref_access(input logic [31:0] a, input logic we, input logic [31:0] d,
                              output logic miss, output logic wb, output logic [31:0] wb_a,
                              output logic [255:0] wb_l, output logic [31:0] rd);
        int idx;
        idx  = int'(a[8:5]);
        miss = !(ref_v[idx] && ref_t[idx] == a[31:9]);
        wb   = miss && ref_v[idx] && ref_d[idx];
        wb_a = {ref_t[idx], a[8:5], 5'b0};
        wb_l = ref_line(wb_a);
        rd   = ref_rd(a);
        if (miss) begin
            ref_v[idx] = 1'b1;
            ref_t[idx] = a[31:9];
            ref_d[idx] = 1'b0;
            exp_misses++;
        end
        exp_hits++;
        if (we) begin
            ref_mem[{a[31:2], 2'b00}] = d;
            ref_d[idx] = 1'b1;
        end
    endtask

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic do_access(input logic [31:0] a, input logic we, input logic [31:0] d,
                             output logic [31:0] rd, output int stalls, output logic ws);
        cpu_addr_i = a;
        cpu_we_i   = we;
        cpu_data_i = d;
        cpu_req_i  = 1'b1;
        stalls     = 0;
        @(negedge clk);
        while (cpu_stall_o === 1'b1 && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        rd = cpu_data_o;
        ws = sram_write_o;
        @(posedge clk);
        #1;
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
    endtask

    task automatic run_chk(input string nm, input logic [31:0] a, input logic we,
                           input logic [31:0] d, output logic [31:0] rd);
        logic         e_miss, e_wb, ws;
        logic [31:0]  e_wb_a, e_rd;
        logic [255:0] e_wb_l;
        int           st, wb0, f0;
        wb0 = wb_addr_q.size();
        f0  = fill_cnt;
        ref_access(a, we, d, e_miss, e_wb, e_wb_a, e_wb_l, e_rd);
        do_access(a, we, d, rd, st, ws);
        chk({nm, "_stall"}, 256'(st), 256'(e_miss ? (e_wb ? DIRTY_STALL : CLEAN_STALL) : 0));
        chk({nm, "_wstrobe"}, 256'(ws), 256'(we));
        if (!we) chk({nm, "_rdata"}, 256'(rd), 256'(e_rd));
        chk({nm, "_wbcount"}, 256'(wb_addr_q.size() - wb0), 256'(e_wb));
        chk({nm, "_fillcount"}, 256'(fill_cnt - f0), 256'(e_miss));
        if (e_wb && wb_addr_q.size() > wb0) begin
            chk({nm, "_wbaddr"}, 256'(wb_addr_q[$]), 256'(e_wb_a));
            chk({nm, "_wbdata"}, wb_data_q[$], e_wb_l);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  rd, tmp;
        logic [255:0] ltmp;
        logic         e_miss, e_wb;
        logic [31:0]  e_wb_a, e_rd;
        logic [255:0] e_wb_l;
        int           cnt, wb0, f0;

        rst_n = 1'b0;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
        for (int i = 0; i < 16; i++) begin
            s_tag[i]  = '0;
            s_data[i] = '0;
        end
        mem_store[32'h100] = {8{32'hA5A5_A5A5}};
        for (int i = 0; i < 8; i++) ref_mem[32'h100 + 32'(4*i)] = 32'hA5A5_A5A5;

        #2;
        chk("rst_stall", 256'(cpu_stall_o), 256'(0));
        chk("rst_mem_en", 256'(mem_enable_o), 256'(0));
        chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        chk("rst_sram_en", 256'(sram_enable_o), 256'(0));
        chk("rst_cpu_data", 256'(cpu_data_o), 256'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // cold read
        run_chk("cold_rd", 32'h0000_0104, 1'b0, 32'h0, rd);
        chk("cold_rd_val", 256'(rd), 256'(32'hA5A5_A5A5));
        chk("cold_fill_addr", 256'(last_fill_addr), 256'(32'h100));

        // store hit then load hit
        run_chk("st_hit", 32'h0000_0108, 1'b1, 32'hDEAD_BEEF, rd);
        chk("st_dirty", 256'(s_tag[8][DC_DIRTY_BIT]), 256'(1));
        chk("st_valid", 256'(s_tag[8][DC_VALID_BIT]), 256'(1));
        run_chk("ld_hit", 32'h0000_0108, 1'b0, 32'h0, rd);
        chk("ld_hit_val", 256'(rd), 256'(32'hDEAD_BEEF));

        // conflict misses in set 8 with dirty victims
        run_chk("conf_a", 32'h0000_0300, 1'b0, 32'h0, rd);
        chk("conf_a_wbaddr", 256'(wb_addr_q[$]), 256'(32'h100));
        ltmp = wb_data_q[$];
        tmp  = ltmp[64 +: 32];
        chk("conf_a_wbword", 256'(tmp), 256'(32'hDEAD_BEEF));
        chk("conf_a_fill", 256'(last_fill_addr), 256'(32'h300));
        run_chk("conf_st", 32'h0000_030C, 1'b1, 32'h1234_5678, rd);
        run_chk("conf_b", 32'h0000_0500, 1'b0, 32'h0, rd);
        chk("conf_b_wbaddr", 256'(wb_addr_q[$]), 256'(32'h300));
        chk("conf_b_fill", 256'(last_fill_addr), 256'(32'h500));

        // reset while a fill is outstanding
        f0 = fill_cnt;
        cpu_addr_i = 32'h0000_1000; cpu_we_i = 1'b0; cpu_req_i = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!(mem_enable_o === 1'b1 && mem_write_o === 1'b0) && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        chk("rm_reached", 256'(cnt < 50), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("rm_rst_mem_en", 256'(mem_enable_o), 256'(0));
        chk("rm_rst_stall", 256'(cpu_stall_o), 256'(0));
        chk("rm_rst_mem_addr", 256'(mem_addr_o), 256'(0));
        cpu_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_hits = 0;
        exp_misses = 0;
        chk("rm_no_fill", 256'(fill_cnt - f0), 256'(0));
        run_chk("post_rst", 32'h0000_1000, 1'b0, 32'h0, rd);

        // request dropped during writeback
        run_chk("pre_st", 32'h0000_0504, 1'b1, 32'hCAFE_F00D, rd);
        wb0 = wb_addr_q.size();
        f0  = fill_cnt;
        ref_access(32'h0000_0700, 1'b0, 32'h0, e_miss, e_wb, e_wb_a, e_wb_l, e_rd);
        exp_hits--;  // retry never happens once the request is withdrawn
        cpu_addr_i = 32'h0000_0700; cpu_we_i = 1'b0; cpu_req_i = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!(mem_enable_o === 1'b1 && mem_write_o === 1'b1) && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        chk("drop_in_wb", 256'(cnt < 50), 256'(1));
        cpu_req_i = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (cpu_stall_o === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("drop_done", 256'(cnt < 100), 256'(1));
        chk("drop_wbcount", 256'(wb_addr_q.size() - wb0), 256'(e_wb));
        chk("drop_wbaddr", 256'(wb_addr_q[$]), 256'(32'h500));
        chk("drop_wbdata", wb_data_q[$], e_wb_l);
        chk("drop_fillcount", 256'(fill_cnt - f0), 256'(1));
        chk("drop_fill_addr", 256'(last_fill_addr), 256'(32'h700));
`ifdef DCACHE_PERF_CNT_EN
        chk("drop_miss_cnt", 256'(miss_cnt), 256'(exp_misses));
`endif
        @(posedge clk);
        #1;
        run_chk("after_drop", 32'h0000_0700, 1'b0, 32'h0, rd);

        // randomized traffic over a few tags colliding in a few sets
        for (int i = 0; i < 40; i++) begin
            logic [22:0] t;
            logic [3:0]  ix;
            logic [2:0]  w;
            logic        we;
            t = 23'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: ix = 4'd0;
                1: ix = 4'd1;
                2: ix = 4'd8;
                default: ix = 4'($urandom_range(0, 15));
            endcase
            w  = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            run_chk("rnd", {t, ix, w, 2'b00}, we, $urandom, rd);
        end

`ifdef DCACHE_PERF_CNT_EN
        chk("hit_cnt", 256'(hit_cnt), 256'(exp_hits));
        chk("miss_cnt", 256'(miss_cnt), 256'(exp_misses));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
